// File: rtl/wb_arbiter_pkg.sv
// Shared writeback types, source ids and the ROB age helper.
// The ROB and the FU flush logic use rob_is_younger() as well.
package wb_arbiter_pkg;

  localparam int NUM_WB_REQ   = 3;
  localparam int WB_SRC_ALU   = 0;
  localparam int WB_SRC_BR    = 1;
  localparam int WB_SRC_LSU   = 2;

  localparam int WB_DATA_W    = 32;
  localparam int WB_PREG_W    = 7;
  localparam int WB_ROB_TAG_W = 4;
  localparam int WB_SRC_W     = 2;

  typedef struct packed {
    logic                    has_rd;
    logic [WB_PREG_W-1:0]    preg;
    logic [WB_DATA_W-1:0]    data;
    logic [WB_ROB_TAG_W-1:0] rob_tag;
  } wb_req_t;

  // Ages are distances from the ROB head, so wrap-around compares correctly.
  function automatic logic rob_is_younger(input logic [WB_ROB_TAG_W-1:0] tag,
                                          input logic [WB_ROB_TAG_W-1:0] ref_tag,
                                          input logic [WB_ROB_TAG_W-1:0] head_tag);
    logic [WB_ROB_TAG_W-1:0] age_tag;
    logic [WB_ROB_TAG_W-1:0] age_ref;
    age_tag = tag - head_tag;
    age_ref = ref_tag - head_tag;
    return age_tag > age_ref;
  endfunction

endpackage

// File: rtl/wb_arbiter_fifo.sv
// Per-requester result buffer with a live bit per entry.
// A flush clears live on younger entries; dead entries are dropped at the head.
module wb_req_fifo
  import wb_arbiter_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    push,
  input  wb_req_t                 push_req,
  input  logic                    pop,
  input  logic                    flush,
  input  logic [WB_ROB_TAG_W-1:0] flush_tag,
  input  logic [WB_ROB_TAG_W-1:0] head_tag,
  output logic                    ready,
  output logic                    head_valid,
  output logic                    head_live,
  output wb_req_t                 head_req
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] DEPTH_C = (PTR_W+1)'(DEPTH);

  wb_req_t          mem_q [DEPTH];
  wb_req_t          mem_d [DEPTH];
  logic [DEPTH-1:0] live_q, live_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W:0]   count_q, count_d;
  logic             do_push;
  logic             do_pop;
  logic             not_full;

  assign not_full   = count_q < DEPTH_C;
  assign ready      = reset & not_full;
  assign head_valid = count_q != '0;
  assign head_live  = live_q[rd_ptr_q];
  assign head_req   = mem_q[rd_ptr_q];

  always_comb begin
    mem_d    = mem_q;
    live_d   = live_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    do_push  = push & not_full;
    do_pop   = pop & head_valid;

    if (flush) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (rob_is_younger(mem_q[i].rob_tag, flush_tag, head_tag)) live_d[i] = 1'b0;
      end
    end

    if (do_push) begin
      mem_d[wr_ptr_q]  = push_req;
      live_d[wr_ptr_q] = ~(flush & rob_is_younger(push_req.rob_tag, flush_tag, head_tag));
      wr_ptr_d         = wr_ptr_q + 1'b1;
    end

    if (do_pop) rd_ptr_d = rd_ptr_q + 1'b1;

    count_d = count_q + (PTR_W+1)'(do_push) - (PTR_W+1)'(do_pop);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      live_q   <= '0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= mem_d[i];
      live_q   <= live_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/wb_arbiter.sv
// Round-robin writeback arbiter: three FU result buffers share one PRF write
// port and one ROB completion port, with squash of results behind a mispredict.
module wb_arbiter
  import wb_arbiter_pkg::*;
#(
  parameter int NUM_REQ   = NUM_WB_REQ,
  parameter int BUF_DEPTH = 2,
  parameter int DATA_W    = WB_DATA_W,
  parameter int PREG_W    = WB_PREG_W,
  parameter int ROB_TAG_W = WB_ROB_TAG_W
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic [NUM_REQ-1:0]                req_valid,
  output logic [NUM_REQ-1:0]                req_ready,
  input  logic [NUM_REQ-1:0]                req_has_rd,
  input  logic [NUM_REQ-1:0][PREG_W-1:0]    req_preg,
  input  logic [NUM_REQ-1:0][DATA_W-1:0]    req_data,
  input  logic [NUM_REQ-1:0][ROB_TAG_W-1:0] req_rob_tag,
  input  logic                              mispredict,
  input  logic [ROB_TAG_W-1:0]              mispredict_tag,
  input  logic [ROB_TAG_W-1:0]              rob_head_tag,
  output logic                              wb_valid,
  output logic                              wb_we,
  output logic [PREG_W-1:0]                 wb_preg,
  output logic [DATA_W-1:0]                 wb_data,
  output logic [ROB_TAG_W-1:0]              wb_rob_tag,
  output logic [WB_SRC_W-1:0]               wb_src
);

  wb_req_t               push_req [NUM_REQ];
  wb_req_t               head_req [NUM_REQ];
  logic [NUM_REQ-1:0]    head_valid;
  logic [NUM_REQ-1:0]    head_live;
  logic [NUM_REQ-1:0]    cand;
  logic [NUM_REQ-1:0]    dead;
  logic [NUM_REQ-1:0]    pop;

  logic                  found;
  logic                  kill;
  logic [WB_SRC_W-1:0]   win;
  int                    idx;

  logic                  wb_valid_q,   wb_valid_d;
  logic                  wb_we_q,      wb_we_d;
  logic [PREG_W-1:0]     wb_preg_q,    wb_preg_d;
  logic [DATA_W-1:0]     wb_data_q,    wb_data_d;
  logic [ROB_TAG_W-1:0]  wb_rob_tag_q, wb_rob_tag_d;
  logic [WB_SRC_W-1:0]   wb_src_q,     wb_src_d;
  logic [WB_SRC_W-1:0]   rr_ptr_q,     rr_ptr_d;

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_req
    assign push_req[g] = '{has_rd:  req_has_rd[g],
                           preg:    req_preg[g],
                           data:    req_data[g],
                           rob_tag: req_rob_tag[g]};

    wb_req_fifo #(.DEPTH(BUF_DEPTH)) u_fifo (
      .clk        (clk),
      .reset      (reset),
      .push       (req_valid[g]),
      .push_req   (push_req[g]),
      .pop        (pop[g]),
      .flush      (mispredict),
      .flush_tag  (mispredict_tag),
      .head_tag   (rob_head_tag),
      .ready      (req_ready[g]),
      .head_valid (head_valid[g]),
      .head_live  (head_live[g]),
      .head_req   (head_req[g])
    );
  end

  assign cand = head_valid & head_live;
  assign dead = head_valid & ~head_live;

  always_comb begin
    found = 1'b0;
    win   = '0;
    idx   = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = int'(rr_ptr_q) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (!found && cand[idx]) begin
        found = 1'b1;
        win   = WB_SRC_W'(idx);
      end
    end

    // A younger winner is still popped, but never reaches the port.
    kill = found & mispredict &
           rob_is_younger(head_req[win].rob_tag, mispredict_tag, rob_head_tag);

    pop = dead;
    if (found) pop[win] = 1'b1;

    wb_valid_d   = found & ~kill;
    wb_we_d      = 1'b0;
    wb_preg_d    = wb_preg_q;
    wb_data_d    = wb_data_q;
    wb_rob_tag_d = wb_rob_tag_q;
    wb_src_d     = wb_src_q;
    rr_ptr_d     = rr_ptr_q;

    if (wb_valid_d) begin
      wb_we_d      = head_req[win].has_rd;
      wb_preg_d    = head_req[win].preg;
      wb_data_d    = head_req[win].data;
      wb_rob_tag_d = head_req[win].rob_tag;
      wb_src_d     = win;
      rr_ptr_d     = (win == WB_SRC_W'(NUM_REQ-1)) ? '0 : win + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wb_valid_q   <= 1'b0;
      wb_we_q      <= 1'b0;
      wb_preg_q    <= '0;
      wb_data_q    <= '0;
      wb_rob_tag_q <= '0;
      wb_src_q     <= '0;
      rr_ptr_q     <= '0;
    end else begin
      wb_valid_q   <= wb_valid_d;
      wb_we_q      <= wb_we_d;
      wb_preg_q    <= wb_preg_d;
      wb_data_q    <= wb_data_d;
      wb_rob_tag_q <= wb_rob_tag_d;
      wb_src_q     <= wb_src_d;
      rr_ptr_q     <= rr_ptr_d;
    end
  end

  assign wb_valid   = wb_valid_q;
  assign wb_we      = wb_we_q;
  assign wb_preg    = wb_preg_q;
  assign wb_data    = wb_data_q;
  assign wb_rob_tag = wb_rob_tag_q;
  assign wb_src     = wb_src_q;

endmodule

// File: tb/tb_wb_arbiter.sv
// Directed bench for wb_arbiter: latency, round-robin order, squash and reset.
module tb_wb_arbiter;

  logic             clk;
  logic             reset;
  logic [2:0]       req_valid;
  logic [2:0]       req_ready;
  logic [2:0]       req_has_rd;
  logic [2:0][6:0]  req_preg;
  logic [2:0][31:0] req_data;
  logic [2:0][3:0]  req_rob_tag;
  logic             mispredict;
  logic [3:0]       mispredict_tag;
  logic [3:0]       rob_head_tag;
  logic             wb_valid;
  logic             wb_we;
  logic [6:0]       wb_preg;
  logic [31:0]      wb_data;
  logic [3:0]       wb_rob_tag;
  logic [1:0]       wb_src;

  int total;
  int bad;

  wb_arbiter dut (
    .clk            (clk),
    .reset          (reset),
    .req_valid      (req_valid),
    .req_ready      (req_ready),
    .req_has_rd     (req_has_rd),
    .req_preg       (req_preg),
    .req_data       (req_data),
    .req_rob_tag    (req_rob_tag),
    .mispredict     (mispredict),
    .mispredict_tag (mispredict_tag),
    .rob_head_tag   (rob_head_tag),
    .wb_valid       (wb_valid),
    .wb_we          (wb_we),
    .wb_preg        (wb_preg),
    .wb_data        (wb_data),
    .wb_rob_tag     (wb_rob_tag),
    .wb_src         (wb_src)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic clear_inputs();
    req_valid      = '0;
    req_has_rd     = '0;
    req_preg       = '0;
    req_data       = '0;
    req_rob_tag    = '0;
    mispredict     = 1'b0;
    mispredict_tag = '0;
    rob_head_tag   = '0;
  endtask

  task automatic do_reset();
    clear_inputs();
    reset = 1'b0;
    @(posedge clk);
    @(posedge clk); #1;
    reset = 1'b1;
  endtask

  task automatic test_reset();
    clear_inputs();
    reset = 1'b0;
    #1;
    total++; if (wb_valid !== 1'b0) begin bad++; $display("FAIL rst_wb_valid got=%0b exp=0", wb_valid); end
    total++; if (wb_we !== 1'b0) begin bad++; $display("FAIL rst_wb_we got=%0b exp=0", wb_we); end
    total++; if (req_ready !== 3'b000) begin bad++; $display("FAIL rst_ready got=%b exp=000", req_ready); end
    total++; if ({wb_preg, wb_data, wb_rob_tag, wb_src} !== '0) begin bad++; $display("FAIL rst_fields got=%h/%h/%h/%h exp=0", wb_preg, wb_data, wb_rob_tag, wb_src); end
    @(posedge clk); #1;
    reset = 1'b1;
    #1;
    total++; if (req_ready !== 3'b111) begin bad++; $display("FAIL rst_release_ready got=%b exp=111", req_ready); end
  endtask

  task automatic test_single_alu();
    do_reset();
    @(posedge clk); #1;
    req_valid[0] = 1'b1; req_has_rd[0] = 1'b1; req_preg[0] = 7'd5;
    req_data[0] = 32'hDEADBEEF; req_rob_tag[0] = 4'd3;
    @(posedge clk); #1;
    req_valid = '0;
    total++; if (wb_valid !== 1'b0) begin bad++; $display("FAIL t1_early got=%0b exp=0", wb_valid); end
    @(posedge clk); #1;
    total++; if (wb_valid !== 1'b1) begin bad++; $display("FAIL t1_valid got=%0b exp=1", wb_valid); end
    total++; if (wb_we !== 1'b1) begin bad++; $display("FAIL t1_we got=%0b exp=1", wb_we); end
    total++; if (wb_preg !== 7'd5) begin bad++; $display("FAIL t1_preg got=%0d exp=5", wb_preg); end
    total++; if (wb_data !== 32'hDEADBEEF) begin bad++; $display("FAIL t1_data got=%h exp=deadbeef", wb_data); end
    total++; if (wb_rob_tag !== 4'd3) begin bad++; $display("FAIL t1_tag got=%0d exp=3", wb_rob_tag); end
    total++; if (wb_src !== 2'd0) begin bad++; $display("FAIL t1_src got=%0d exp=0", wb_src); end
    @(posedge clk); #1;
    total++; if (wb_valid !== 1'b0) begin bad++; $display("FAIL t1_after got=%0b exp=0", wb_valid); end
  endtask

  task automatic test_back_to_back();
    int  k [3];
    int  got;
    bit  saw_full;
    logic [1:0]  exp_src;
    logic [31:0] exp_data;
    do_reset();
    k = '{0, 0, 0};
    got = 0;
    saw_full = 1'b0;
    for (int cyc = 0; cyc < 40; cyc++) begin
      @(posedge clk); #1;
      if (wb_valid === 1'b1) begin
        if (got < 12) begin
          exp_src  = 2'(got % 3);
          exp_data = 32'(256 * (got % 3) + got / 3);
          total++; if (wb_src !== exp_src) begin bad++; $display("FAIL b2b_src[%0d] got=%0d exp=%0d", got, wb_src, exp_src); end
          total++; if (wb_data !== exp_data) begin bad++; $display("FAIL b2b_data[%0d] got=%h exp=%h", got, wb_data, exp_data); end
          total++; if (wb_preg !== 7'(exp_src + 2'd1) || wb_we !== 1'b1) begin bad++; $display("FAIL b2b_preg[%0d] got=%0d/%0b exp=%0d/1", got, wb_preg, wb_we, exp_src + 2'd1); end
        end else begin
          total++; bad++; $display("FAIL b2b_extra got=result%0d exp=none", got);
        end
        got++;
      end
      for (int i = 0; i < 3; i++) begin
        if (k[i] < 4) begin
          req_valid[i]   = 1'b1;
          req_has_rd[i]  = 1'b1;
          req_preg[i]    = 7'(i + 1);
          req_data[i]    = 32'(256 * i + k[i]);
          req_rob_tag[i] = 4'(k[i]);
        end else begin
          req_valid[i] = 1'b0;
        end
      end
      @(negedge clk);
      for (int i = 0; i < 3; i++) begin
        if (req_valid[i] && req_ready[i]) k[i]++;
        else if (req_valid[i]) saw_full = 1'b1;
      end
    end
    req_valid = '0;
    total++; if (got !== 12) begin bad++; $display("FAIL b2b_count got=%0d exp=12", got); end
    total++; if (saw_full !== 1'b1) begin bad++; $display("FAIL b2b_ready_low got=%0b exp=1", saw_full); end
  endtask

  task automatic test_no_rd();
    do_reset();
    @(posedge clk); #1;
    req_valid[1] = 1'b1; req_has_rd[1] = 1'b0; req_preg[1] = 7'd9;
    req_data[1] = 32'h12345678; req_rob_tag[1] = 4'd7;
    @(posedge clk); #1;
    req_valid = '0;
    @(posedge clk); #1;
    total++; if (wb_valid !== 1'b1) begin bad++; $display("FAIL t3_valid got=%0b exp=1", wb_valid); end
    total++; if (wb_we !== 1'b0) begin bad++; $display("FAIL t3_we got=%0b exp=0", wb_we); end
    total++; if (wb_rob_tag !== 4'd7) begin bad++; $display("FAIL t3_tag got=%0d exp=7", wb_rob_tag); end
    total++; if (wb_src !== 2'd1) begin bad++; $display("FAIL t3_src got=%0d exp=1", wb_src); end
  endtask

  task automatic push_all_old(input logic [3:0] tag);
    @(posedge clk); #1;
    req_valid = 3'b111; req_has_rd = 3'b111; req_rob_tag = {tag, tag, tag};
    req_data = {32'hC2, 32'hC1, 32'hC0};
    @(posedge clk); #1;
    req_valid = '0;
  endtask

  task automatic test_flush_buffered();
    logic [1:0] exp_order [3];
    do_reset();
    rob_head_tag = 4'd14;
    @(posedge clk); #1;
    req_valid = 3'b111; req_has_rd = 3'b111;
    req_rob_tag = {4'd3, 4'd1, 4'd15};
    req_data = {32'hA2, 32'hA1, 32'hA0};
    @(posedge clk); #1;
    req_valid = '0;
    mispredict = 1'b1; mispredict_tag = 4'd0;
    @(posedge clk); #1;
    mispredict = 1'b0;
    total++; if (wb_valid !== 1'b1 || wb_rob_tag !== 4'd15 || wb_src !== 2'd0) begin bad++; $display("FAIL t4_keep got=%0b/%0d/%0d exp=1/15/0", wb_valid, wb_rob_tag, wb_src); end
    @(posedge clk); #1;
    total++; if (wb_valid !== 1'b0) begin bad++; $display("FAIL t4_drop1 got=%0b/tag%0d exp=0", wb_valid, wb_rob_tag); end
    @(posedge clk); #1;
    total++; if (wb_valid !== 1'b0) begin bad++; $display("FAIL t4_drop2 got=%0b/tag%0d exp=0", wb_valid, wb_rob_tag); end
    total++; if (req_ready !== 3'b111) begin bad++; $display("FAIL t4_empty got=%b exp=111", req_ready); end
    push_all_old(4'd14);
    exp_order = '{2'd1, 2'd2, 2'd0};
    for (int n = 0; n < 3; n++) begin
      @(posedge clk); #1;
      total++; if (wb_valid !== 1'b1 || wb_src !== exp_order[n]) begin bad++; $display("FAIL t4_rr[%0d] got=%0b/%0d exp=1/%0d", n, wb_valid, wb_src, exp_order[n]); end
    end
  endtask

  task automatic test_flush_same_cycle();
    logic [1:0] exp_order [3];
    do_reset();
    rob_head_tag = 4'd0;
    @(posedge clk); #1;
    req_valid[1] = 1'b1; req_has_rd[1] = 1'b1; req_rob_tag[1] = 4'd5; req_data[1] = 32'hB1;
    @(posedge clk); #1;
    req_valid = 3'b100; req_has_rd[2] = 1'b1; req_rob_tag[2] = 4'd6; req_data[2] = 32'hB2;
    mispredict = 1'b1; mispredict_tag = 4'd2;
    @(posedge clk); #1;
    req_valid = '0; mispredict = 1'b0;
    for (int n = 0; n < 3; n++) begin
      total++; if (wb_valid !== 1'b0) begin bad++; $display("FAIL t5_squash[%0d] got=%0b/tag%0d exp=0", n, wb_valid, wb_rob_tag); end
      @(posedge clk); #1;
    end
    push_all_old(4'd0);
    exp_order = '{2'd0, 2'd1, 2'd2};
    for (int n = 0; n < 3; n++) begin
      @(posedge clk); #1;
      total++; if (wb_valid !== 1'b1 || wb_src !== exp_order[n]) begin bad++; $display("FAIL t5_rr[%0d] got=%0b/%0d exp=1/%0d", n, wb_valid, wb_src, exp_order[n]); end
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    @(posedge clk); #1;
    req_valid = 3'b111; req_has_rd = 3'b111;
    req_data = {32'hE2, 32'hE1, 32'hE0}; req_rob_tag = {4'd2, 4'd1, 4'd0};
    repeat (6) @(posedge clk);
    #1;
    total++; if (wb_valid !== 1'b1) begin bad++; $display("FAIL t6_busy got=%0b exp=1", wb_valid); end
    reset = 1'b0;
    #1;
    req_valid = '0;
    total++; if (wb_valid !== 1'b0 || wb_we !== 1'b0) begin bad++; $display("FAIL t6_wb_clear got=%0b/%0b exp=0/0", wb_valid, wb_we); end
    total++; if (wb_data !== 32'h0) begin bad++; $display("FAIL t6_data_clear got=%h exp=0", wb_data); end
    total++; if (req_ready !== 3'b000) begin bad++; $display("FAIL t6_ready_low got=%b exp=000", req_ready); end
    @(posedge clk); #1;
    reset = 1'b1;
    #1;
    total++; if (req_ready !== 3'b111) begin bad++; $display("FAIL t6_ready_high got=%b exp=111", req_ready); end
    for (int n = 0; n < 6; n++) begin
      @(posedge clk); #1;
      total++; if (wb_valid !== 1'b0) begin bad++; $display("FAIL t6_stale[%0d] got=%0b/%h exp=0", n, wb_valid, wb_data); end
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    test_reset();
    test_single_alu();
    test_back_to_back();
    test_no_rd();
    test_flush_buffered();
    test_flush_same_cycle();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
